// File: rtl/rb_unsteer_reader.sv
// Row-buffer un-steer reader: sweeps one BRAM row, undoes the write-side
// lane rotation and streams the restored pixel columns through a 2-entry
// skid FIFO with valid/ready flow control.
module rb_unsteer_reader #(
    parameter int ROW_WORDS = 512,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        row_sel,
    output logic              busy,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [31:0]       bram_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic              m_last,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_WORDS - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        sel_q;
    logic              inflight;
    logic              inflight_last;
    beat_t [1:0]       fifo;
    logic [1:0]        fcnt;
    logic              pop;
    logic              issue;
    logic [2:0]        occ;
    beat_t             incoming;

    // Rotate left by whole byte lanes to undo the write-side steering
    function automatic logic [31:0] derot(input logic [31:0] w, input logic [1:0] s);
        logic [31:0] r;
        case (s)
            2'd0:    r = w;
            2'd1:    r = {w[23:0], w[31:24]};
            2'd2:    r = {w[15:0], w[31:16]};
            default: r = {w[7:0],  w[31:8]};
        endcase
        return r;
    endfunction

    assign m_valid  = (fcnt != 2'd0);
    assign m_data   = fifo[0].data;
    assign m_last   = m_valid & fifo[0].last;
    assign pop      = m_valid & m_ready;
    assign busy     = (state != IDLE);

    // Occupancy counts the buffered beats plus the read whose data lands this
    // cycle; a new read is only issued if its data is guaranteed a FIFO slot.
    assign occ      = {1'b0, fcnt} + {2'b00, inflight};
    assign issue    = (state == READ) && (occ < 3'd2 + {2'b00, pop});
    assign bram_en  = issue;
    assign bram_addr = cnt;
    assign incoming = '{last: inflight_last, data: derot(bram_dout, sel_q)};

    // Sweep control: address counter, latched rotation, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sel_q         <= 2'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (cnt == LAST_ADDR);
            case (state)
                IDLE: if (start) begin
                    state <= READ;
                    cnt   <= '0;
                    sel_q <= row_sel;
                end
                READ: if (issue) begin
                    if (cnt == LAST_ADDR) state <= DRAIN;
                    else                  cnt   <= cnt + ADDR_W'(1);
                end
                DRAIN: if (pop && m_last) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry FIFO, head always in slot 0 so outputs come straight from a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo <= '0;
            fcnt <= 2'd0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (fcnt == 2'd0) fifo[0] <= incoming;
                    else              fifo[1] <= incoming;
                    fcnt <= fcnt + 2'd1;
                end
                2'b01: begin
                    fifo[0] <= fifo[1];
                    fcnt    <= fcnt - 2'd1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) begin
                        fifo[0] <= incoming;
                    end else begin
                        fifo[0] <= fifo[1];
                        fifo[1] <= incoming;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rb_unsteer_reader.sv
// Bench for rb_unsteer_reader: random BRAM contents and random downstream
// backpressure, checked against an address-ordered reference of the row.
module tb_rb_unsteer_reader;

    localparam int N  = 512;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [1:0]    row_sel = 2'd0;
    logic          busy, bram_en, m_valid, m_last, done;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_dout = 32'd0;
    logic          m_ready = 1'b0;
    logic [31:0]   m_data;

    logic          s_start = 1'b0;
    logic [1:0]    s_sel = 2'd0;
    logic          s_busy, s_en, s_valid, s_last, s_done;
    logic [0:0]    s_addr;
    logic [31:0]   s_dout = 32'd0;
    logic          s_ready = 1'b0;
    logic [31:0]   s_data;

    rb_unsteer_reader #(.ROW_WORDS(N), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_sel(row_sel),
        .busy(busy), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .done(done)
    );

    rb_unsteer_reader #(.ROW_WORDS(1), .ADDR_W(1)) u_one (
        .clk(clk), .rst_n(rst_n), .start(s_start), .row_sel(s_sel),
        .busy(s_busy), .bram_en(s_en), .bram_addr(s_addr), .bram_dout(s_dout),
        .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data), .m_last(s_last), .done(s_done)
    );

    logic [31:0] mem [N];

    // BRAM model: one-cycle registered read
    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
        if (s_en)    s_dout    <= mem[s_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: byte-lane rotate-left by 8*s, taken from a doubled word
    function automatic logic [31:0] ref_derot(input logic [31:0] w, input int s);
        logic [63:0] d;
        d = {w, w};
        return d[63-8*s -: 32];
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"},   bram_en, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_vld"},  m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_data"}, m_data, 0);
    endtask

    // One row sweep. rnd: random m_ready. glitch_at: beat index at which a
    // stray start with a different row_sel is pulsed. rst_at: beat index at
    // which reset is asserted. start_on_last: start held with the final pop.
    task automatic sweep(input int sel, input bit rnd, input int glitch_at,
                         input int rst_at, input bit start_on_last,
                         input logic [31:0] exp0);
        int  nb = 0, iss = 0, cyc = 0, first_v = -1, last_cyc = -1;
        bit  fin = 0, aborted = 0, glitched = 0, stall = 0;
        logic [31:0] pdata = 0;
        logic        plast = 0;
        @(negedge clk);
        row_sel = 2'(sel);
        start   = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        row_sel = 2'(sel + 1);
        while (!fin && cyc < 4*N + 40) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (glitch_at >= 0 && !glitched && nb >= glitch_at) begin
                glitched = 1;
                row_sel  = 2'(sel + 1 + $urandom_range(0, 2));
                start    = 1'b1;
            end
            #1;
            if (cyc == 1) begin
                chk("lat_busy", busy, 1);
                chk("lat_en", bram_en, 1);
            end
            if (stall && m_valid) begin
                chk("hold_data", m_data, pdata);
                chk("hold_last", m_last, plast);
            end
            if (stall) chk("hold_vld", m_valid, 1);
            if (bram_en) begin
                chk("addr", bram_addr, 32'(iss));
                iss++;
            end
            chk("depth_le3", 32'(iss - nb <= 3), 1);
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                if (nb == 0) chk("beat0_const", m_data, exp0);
                chk("data", m_data, ref_derot(mem[nb], sel));
                chk("last", m_last, 32'(nb == N-1));
                nb++;
                if (nb == N) begin
                    last_cyc = cyc;
                    if (start_on_last) start = 1'b1;
                end
            end
            if (last_cyc >= 0 && cyc == last_cyc + 1) begin
                chk("done", done, 1);
                chk("busy_fall", busy, 0);
                fin = 1;
            end else begin
                chk("done_early", done, 0);
            end
            stall = m_valid && !m_ready;
            pdata = m_data;
            plast = m_last;
            if (!fin && rst_at >= 0 && nb == rst_at) begin
                rst_n = 1'b0;
                #1 all_zero("rst_async");
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    #1 all_zero("rst_quiet");
                end
                aborted = 1;
                fin = 1;
            end
        end
        chk("no_timeout", 32'(fin), 1);
        if (!aborted) begin
            chk("reads", 32'(iss), N);
            chk("beats", 32'(nb), N);
            if (!rnd) begin
                chk("first_valid_cyc", 32'(first_v), 3);
                chk("last_beat_cyc", 32'(last_cyc), N + 2);
            end
            repeat (2) begin
                @(negedge clk);
                #1;
                chk("idle_en", bram_en, 0);
                chk("idle_busy", busy, 0);
            end
        end
    endtask

    initial begin
        int ens, beats, dones;
        for (int i = 0; i < N; i++) mem[i] = $urandom;
        mem[0] = 32'hAABBCCDD;

        #1 all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 all_zero("post_reset");
        end

        sweep(0, 0, -1, -1, 0, 32'hAABBCCDD);
        sweep(1, 1, 50, -1, 1, 32'hBBCCDDAA);
        sweep(2, 1, -1, -1, 0, 32'hCCDDAABB);
        sweep(3, 0, 7,  -1, 1, 32'hDDAABBCC);
        sweep(1, 0, -1, 100, 0, 32'hBBCCDDAA);
        sweep(2, 1, -1, -1, 0, 32'hCCDDAABB);

        // Single-word row
        @(negedge clk);
        s_sel   = 2'd2;
        s_start = 1'b1;
        s_ready = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        ens = 0; beats = 0; dones = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (s_en) begin
                ens++;
                chk("one_addr", 32'(s_addr), 0);
            end
            if (s_valid && s_ready) begin
                beats++;
                chk("one_data", s_data, ref_derot(mem[0], 2));
                chk("one_last", s_last, 1);
            end
            if (s_done) dones++;
        end
        chk("one_reads", 32'(ens), 1);
        chk("one_beats", 32'(beats), 1);
        chk("one_done", 32'(dones), 1);
        chk("one_busy", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rb_unsteer_reader.md
RB_UNSTEER_READER -- requirements
Module: rb_unsteer_reader

Interface
REQ-001 Parameter ROW_WORDS, default 512: number of 32-bit BRAM words in one row sweep; legal range 1..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 9: BRAM address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin a row sweep.
REQ-006 row_sel  in  2  lane rotation applied by the write-side steering for this sweep; sampled with start.
REQ-007 busy  out  1  high from the cycle after start is accepted until done.
REQ-008 bram_en  out  1  BRAM read enable.
REQ-009 bram_addr  out  ADDR_W  BRAM read address.
REQ-010 bram_dout  in  32  BRAM read data, valid exactly 1 cycle after bram_en.
REQ-011 m_valid  out  1  output beat valid.
REQ-012 m_ready  in  1  downstream accept.
REQ-013 m_data  out  32  de-rotated pixel column, row order restored: [31:24] newest row down to [7:0] oldest row.
REQ-014 m_last  out  1  high with the final beat (word ROW_WORDS-1).
REQ-015 done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-016 De-rotation: m_data = bram word rotated left by 8*row_sel bits. For word {B3,B2,B1,B0}: sel 0 -> {B3,B2,B1,B0}; 1 -> {B2,B1,B0,B3}; 2 -> {B1,B0,B3,B2}; 3 -> {B0,B3,B2,B1}.
REQ-017 Rotation amount is the row_sel value latched at start; it is held constant for the entire sweep.
REQ-018 FSM states: IDLE, READ, DRAIN.
REQ-019 IDLE -> READ when start=1; addr counter cleared to 0; row_sel latched.
REQ-020 READ: issue a read (bram_en=1, bram_addr=counter, counter+1) when count + inflight - pop < 2, where count = buffered beats, inflight = reads issued last cycle, pop = m_valid & m_ready.
REQ-021 READ -> DRAIN in the cycle the read of address ROW_WORDS-1 is issued.
REQ-022 DRAIN -> IDLE when the m_last beat is accepted; done pulses in the following cycle; busy falls with done.
REQ-023 Returned data is captured into a 2-entry FIFO; m_data/m_valid/m_last are driven from the FIFO head; no beat is dropped or duplicated.
REQ-024 Latency: start at edge T -> bram_en high in cycle T+1 (addr 0) -> m_valid high in cycle T+3.
REQ-025 Throughput: with m_ready held high, one beat per cycle after the first; ROW_WORDS beats in ROW_WORDS+2 cycles after start.
REQ-026 m_ready low: m_data, m_last stable while m_valid is high; reads stall by REQ-020; FIFO never exceeds 2 entries.
REQ-027 start while busy=1 is ignored; row_sel changes during a sweep have no effect.
REQ-028 ROW_WORDS=1: single read, single beat with m_last=1.
REQ-029 bram_addr never exceeds ROW_WORDS-1; no wrap within a sweep.
REQ-030 start and the final pop in the same cycle: start ignored (busy still high).

Reset
REQ-031 rst_n low, at any time including mid-sweep: FSM=IDLE, counter=0, FIFO emptied, inflight cleared, latched row_sel=0; busy, bram_en, m_valid, m_last, done = 0; bram_addr=0; m_data=0.
REQ-032 After rst_n rises, no output changes until the next start.

Verification
REQ-033 ROW_WORDS=4, row_sel=1, BRAM words 0x11223344.. per address, m_ready=1 -> beats 0x22334411 etc. in order, m_valid first in cycle T+3, m_last on beat 4, done one cycle later.
REQ-034 row_sel sweep 0..3 on word 0xAABBCCDD -> 0xAABBCCDD, 0xBBCCDDAA, 0xCCDDAABB, 0xDDAABBCC.
REQ-035 m_ready toggling 1,0,0,1 random for 512 words -> all 512 beats exact and in order, FIFO depth never >2, bram_addr monotonic 0..511.
REQ-036 rst_n asserted at beat 100 of a sweep -> all outputs 0 asynchronously; new start gives a clean sweep from addr 0.
REQ-037 start pulsed during busy with row_sel changed -> ignored; rotation of current sweep unchanged.
REQ-038 ROW_WORDS=1 -> exactly one bram_en, one beat with m_last=1, done pulse.
